// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared definitions for the 8:1 TDM mux/demux path
package tdm_pkg;

    localparam int LANES_DEF = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_demux8_if.sv
// rtl/tdm_demux8_if.sv - serial slot input and recovered frame outputs of the demux
interface tdm_demux8_if #(
    parameter int LANES = 8,
    parameter int SEL_W = 3
);
    logic             din;
    logic             din_valid;
    logic             sync;
    logic [SEL_W-1:0] sel;
    logic [LANES-1:0] lanes;
    logic [LANES-1:0] frame;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;

    modport slave (
        input  din, din_valid, sync,
        output sel, lanes, frame, frame_valid, locked, sync_err
    );

    modport master (
        output din, din_valid, sync,
        input  sel, lanes, frame, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-LANES slot counter with realign-to-slot-0
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load0,
    output logic [SEL_W-1:0] sel,
    output logic             wrap
);
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    // A realigning bit occupies slot 0, so the counter lands on 1 afterwards.
    always_comb begin
        sel_d = sel_q;
        if (en) begin
            if (load0) begin
                sel_d = SEL_W'(1);
            end else if (sel_q == SEL_W'(LANES - 1)) begin
                sel_d = '0;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel  = sel_q;
    assign wrap = en && (sel_q == SEL_W'(LANES - 1));
endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-slot TDM demultiplexer with sync-marker framing
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux8_if.slave  bus
);
    tdm_state_t       state_q, state_d;
    logic [LANES-1:0] lanes_q, lanes_d;
    logic [LANES-1:0] shadow_q, shadow_d;
    logic [LANES-1:0] frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    logic             accept;
    logic             realign;
    logic             wrap;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] wr_idx;

    // In HUNT only a sync-marked bit is taken; in LOCK every valid bit is.
    assign accept  = bus.din_valid && ((state_q == LOCK) || bus.sync);
    assign realign = bus.din_valid && bus.sync;
    assign wr_idx  = realign ? '0 : sel;

    tdm_slot_counter #(
        .LANES (LANES),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .load0 (realign),
        .sel   (sel),
        .wrap  (wrap)
    );

    always_comb begin
        state_d       = state_q;
        lanes_d       = lanes_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (accept) begin
            lanes_d[wr_idx]  = bus.din;
            shadow_d[wr_idx] = bus.din;
        end

        // A sync landing on slot 7 realigns instead of closing the frame.
        if (wrap && !realign) begin
            frame_d       = {bus.din, shadow_q[LANES-2:0]};
            frame_valid_d = 1'b1;
        end

        if (realign) begin
            state_d = LOCK;
            if ((state_q == LOCK) && (sel != '0)) begin
                sync_err_d = 1'b1;
            end
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= HUNT;
            lanes_q       <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lanes_q       <= lanes_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.sel         = sel;
    assign bus.lanes       = lanes_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - self-checking bench for tdm_demux8 against a slot-level model
module tb_tdm_demux8;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux8_if #(.LANES(8), .SEL_W(3)) bus ();

    tdm_demux8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: slot position as an integer, frames assembled in a byte array.
    bit         m_locked;
    int         m_slot;
    logic [7:0] m_lanes, m_part, m_frame;
    bit         m_fv, m_err;

    task automatic model_clear();
        m_locked = 0; m_slot = 0; m_lanes = 0; m_part = 0; m_frame = 0;
        m_fv = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic d, input logic v, input logic s);
        m_fv  = 0;
        m_err = 0;
        if (v) begin
            if (s) begin
                if (m_locked && m_slot != 0) m_err = 1;
                m_slot   = 0;
                m_locked = 1;
            end
            if (m_locked) begin
                m_lanes[m_slot] = d;
                m_part[m_slot]  = d;
                if (m_slot == 7) begin
                    m_frame = m_part;
                    m_fv    = 1;
                end
                m_slot = (m_slot + 1) % 8;
            end
        end
    endtask

    task automatic step(input logic d, input logic v, input logic s);
        bus.din = d; bus.din_valid = v; bus.sync = s;
        @(posedge clk);
        model_edge(d, v, s);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_sync);
        for (int i = 0; i < 8; i++) step(b[i], 1'b1, with_sync && i == 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.din = 1'($urandom); bus.din_valid = 1'($urandom); bus.sync = 1'($urandom);
            @(negedge clk);
            total++;
            if ({bus.sel, bus.lanes, bus.frame, bus.frame_valid, bus.locked, bus.sync_err} !== 22'd0) begin
                bad++;
                $display("FAIL reset_hold: got sel=%0d lanes=%h frame=%h fv=%b locked=%b err=%b, want all 0",
                         bus.sel, bus.lanes, bus.frame, bus.frame_valid, bus.locked, bus.sync_err);
            end
        end
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_single_frame();
        logic [7:0] b = 8'hAB;
        do_reset();
        step(b[0], 1'b1, 1'b1);
        total++;
        if (bus.locked !== 1'b1 || bus.sel !== 3'd1) begin
            bad++;
            $display("FAIL single_lock: got locked=%b sel=%0d, want locked=1 sel=1", bus.locked, bus.sel);
        end
        for (int i = 1; i < 8; i++) begin
            step(b[i], 1'b1, 1'b0);
            if (i < 7) begin
                total++;
                if (bus.frame_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL single_early_fv: got fv=%b at slot %0d, want 0", bus.frame_valid, i);
                end
            end
        end
        total++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 8'hAB || bus.lanes !== 8'hAB) begin
            bad++;
            $display("FAIL single_frame: got fv=%b frame=%h lanes=%h, want fv=1 frame=ab lanes=ab",
                     bus.frame_valid, bus.frame, bus.lanes);
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.frame_valid !== 1'b0 || bus.frame !== 8'hAB) begin
            bad++;
            $display("FAIL single_pulse: got fv=%b frame=%h, want fv=0 frame=ab", bus.frame_valid, bus.frame);
        end
    endtask

    task automatic test_stall();
        logic [7:0] b = 8'hAB;
        do_reset();
        for (int i = 0; i < 4; i++) step(b[i], 1'b1, i == 0);
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'b0, 1'($urandom));
            total++;
            if (bus.sel !== 3'd4 || bus.frame_valid !== 1'b0 || bus.lanes !== 8'h0B) begin
                bad++;
                $display("FAIL stall_hold: got sel=%0d fv=%b lanes=%h, want sel=4 fv=0 lanes=0b",
                         bus.sel, bus.frame_valid, bus.lanes);
            end
        end
        for (int i = 4; i < 8; i++) step(b[i], 1'b1, 1'b0);
        total++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 8'hAB) begin
            bad++;
            $display("FAIL stall_frame: got fv=%b frame=%h, want fv=1 frame=ab", bus.frame_valid, bus.frame);
        end
    endtask

    task automatic test_prelock();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        total++;
        if (bus.lanes !== 8'h00 || bus.locked !== 1'b0 || bus.sel !== 3'd0) begin
            bad++;
            $display("FAIL prelock_drop: got lanes=%h locked=%b sel=%0d, want 00 0 0", bus.lanes, bus.locked, bus.sel);
        end
        send_byte(8'hAB, 1'b1);
        total++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 8'hAB) begin
            bad++;
            $display("FAIL prelock_frame: got fv=%b frame=%h, want fv=1 frame=ab", bus.frame_valid, bus.frame);
        end
    endtask

    task automatic test_mid_sync();
        logic [7:0] a = 8'hC6;
        logic [7:0] b = 8'h3C;
        do_reset();
        for (int i = 0; i < 4; i++) step(a[i], 1'b1, i == 0);
        step(b[0], 1'b1, 1'b1);
        total++;
        if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.sel !== 3'd1 || bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL mid_sync_err: got err=%b fv=%b sel=%0d locked=%b, want 1 0 1 1",
                     bus.sync_err, bus.frame_valid, bus.sel, bus.locked);
        end
        for (int i = 1; i < 8; i++) begin
            step(b[i], 1'b1, 1'b0);
            total++;
            if (bus.sync_err !== 1'b0 || bus.frame_valid !== (i == 7)) begin
                bad++;
                $display("FAIL mid_sync_pulse: slot %0d got err=%b fv=%b, want err=0 fv=%b",
                         i, bus.sync_err, bus.frame_valid, i == 7);
            end
        end
        total++;
        if (bus.frame !== 8'h3C) begin
            bad++;
            $display("FAIL mid_sync_frame: got frame=%h, want 3c", bus.frame);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({bus.sel, bus.lanes, bus.frame, bus.frame_valid, bus.locked, bus.sync_err} !== 22'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: got sel=%0d lanes=%h locked=%b, want all 0", bus.sel, bus.lanes, bus.locked);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (bus.locked !== 1'b0 || bus.lanes !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_hunt: got locked=%b lanes=%h, want 0 00", bus.locked, bus.lanes);
        end
        send_byte(8'h5A, 1'b1);
        total++;
        if (bus.frame_valid !== 1'b1 || bus.frame !== 8'h5A) begin
            bad++;
            $display("FAIL reset_mid_frame: got fv=%b frame=%h, want fv=1 frame=5a", bus.frame_valid, bus.frame);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h12, 8'hE7, 8'h90};
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                step(bytes[k][i], 1'b1, k == 0 && i == 0);
                if (bus.frame_valid === 1'b1) pulses++;
            end
            total++;
            if (bus.frame_valid !== 1'b1 || bus.frame !== bytes[k]) begin
                bad++;
                $display("FAIL b2b_frame%0d: got fv=%b frame=%h, want fv=1 frame=%h", k, bus.frame_valid, bus.frame, bytes[k]);
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d pulses, want 3", pulses);
        end
    endtask

    task automatic test_random();
        logic d, v, s;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            d = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 11) == 0);
            step(d, v, s);
            total++;
            if (bus.sel !== 3'(m_slot) || bus.lanes !== m_lanes || bus.frame !== m_frame ||
                bus.frame_valid !== m_fv || bus.locked !== m_locked || bus.sync_err !== m_err) begin
                bad++;
                $display("FAIL random_cycle%0d: got sel=%0d lanes=%h frame=%h fv=%b lk=%b err=%b, want %0d %h %h %b %b %b",
                         n, bus.sel, bus.lanes, bus.frame, bus.frame_valid, bus.locked, bus.sync_err,
                         m_slot, m_lanes, m_frame, m_fv, m_locked, m_err);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_stall();
        test_prelock();
        test_mid_sync();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
